// File: rtl/brg_xcel_master_arbiter.sv
// -----------------------------------------------------------------------------
// brg_xcel_master_arbiter
//
// Shares one endpoint master request/response port among num_req_p internal
// requesters (stream-read, stream-write, descriptor fetch, ...).
//
// Request side: round-robin arbitration starting at ptr_r. A request that is
// presented but not accepted locks the grant onto that requester until the
// endpoint takes it. Loads carry load_id = {requester index, requester opq}.
//
// Handshake semantics (all ports):
//   master side : a transfer happens in any cycle where master_v_o && master_rdy_i.
//                 Once master_v_o is raised the grant and payload are held until
//                 that transfer occurs.
//   requester   : req_yumi_o[i] pulses in the same cycle its request is taken
//                 (zero latency). A requester whose request was presented but
//                 not yet taken must keep req_v_i and its payload stable.
//   response    : resp_v_o[i] is a pure valid with no back-pressure; requesters
//                 must consume it in the cycle it is asserted.
//
// Ports:
//   clk_i, reset_i        clock, asynchronous active-high reset
//   req_*_i / req_yumi_o  flattened per-requester request bundles + accept
//   master_*_o / _rdy_i   granted request toward encoder/endpoint
//   master_ret_*_i        returned load data and load_id
//   resp_v_o / resp_*_o   per-requester response valid, shared data/opq
//   idle_o                no loads outstanding and no lock held
//   err_o                 sticky protocol error (dropped locked request,
//                         counter underflow, out-of-range return index)
// -----------------------------------------------------------------------------
module brg_xcel_master_arbiter #(
    parameter int num_req_p         = 2,
    parameter int data_width_p      = 32,
    parameter int addr_width_p      = 32,
    parameter int load_id_width_p   = 11,
    parameter int max_outstanding_p = 16,
    localparam int id_width_lp      = $clog2(num_req_p),
    localparam int opq_width_lp     = load_id_width_p - id_width_lp,
    localparam int mask_width_lp    = data_width_p / 8
) (
    input  logic                                 clk_i,
    input  logic                                 reset_i,

    input  logic [num_req_p-1:0]                 req_v_i,
    input  logic [num_req_p-1:0]                 req_type_i,
    input  logic [num_req_p*addr_width_p-1:0]    req_addr_i,
    input  logic [num_req_p*data_width_p-1:0]    req_data_i,
    input  logic [num_req_p*mask_width_lp-1:0]   req_mask_i,
    input  logic [num_req_p*opq_width_lp-1:0]    req_opq_i,
    output logic [num_req_p-1:0]                 req_yumi_o,

    output logic                                 master_v_o,
    output logic                                 master_type_o,
    output logic [addr_width_p-1:0]              master_addr_o,
    output logic [data_width_p-1:0]              master_data_o,
    output logic [mask_width_lp-1:0]             master_mask_o,
    output logic [load_id_width_p-1:0]           master_opq_o,
    input  logic                                 master_rdy_i,

    input  logic                                 master_ret_v_i,
    input  logic [data_width_p-1:0]              master_ret_data_i,
    input  logic [load_id_width_p-1:0]           master_ret_opq_i,

    output logic [num_req_p-1:0]                 resp_v_o,
    output logic [data_width_p-1:0]              resp_data_o,
    output logic [opq_width_lp-1:0]              resp_opq_o,

    output logic                                 idle_o,
    output logic                                 err_o
);

    localparam int cnt_width_lp = $clog2(max_outstanding_p + 1);
    localparam logic [cnt_width_lp-1:0] cnt_max_lp = cnt_width_lp'(max_outstanding_p);

    // ---------------------------------------------------------------------
    // State
    // ---------------------------------------------------------------------
    logic [id_width_lp-1:0]  ptr_r,      ptr_n;
    logic                    lock_r,     lock_n;
    logic [id_width_lp-1:0]  lock_idx_r, lock_idx_n;
    logic                    err_r,      err_n;
    logic [cnt_width_lp-1:0] cnt_r [num_req_p];
    logic [cnt_width_lp-1:0] cnt_n [num_req_p];

    // ---------------------------------------------------------------------
    // Arbitration
    // ---------------------------------------------------------------------
    logic [num_req_p-1:0]   elig;
    logic [id_width_lp-1:0] rr_idx;
    logic                   rr_found;
    logic [id_width_lp-1:0] grant;
    int                     grant_int;
    logic                   accept;

    always_comb begin
        elig = '0;
        for (int i = 0; i < num_req_p; i++) begin
            elig[i] = req_v_i[i] && (req_type_i[i] || (cnt_r[i] < cnt_max_lp));
        end
    end

    // Lowest eligible index at or above the pointer, else lowest overall.
    always_comb begin
        rr_idx   = '0;
        rr_found = 1'b0;
        for (int i = 0; i < num_req_p; i++) begin
            if (!rr_found && elig[i] && (i >= int'(ptr_r))) begin
                rr_idx   = id_width_lp'(i);
                rr_found = 1'b1;
            end
        end
        for (int i = 0; i < num_req_p; i++) begin
            if (!rr_found && elig[i]) begin
                rr_idx   = id_width_lp'(i);
                rr_found = 1'b1;
            end
        end
    end

    assign grant     = lock_r ? lock_idx_r : rr_idx;
    assign grant_int = int'(grant);

    // While locked only the locked requester's valid matters; its eligibility
    // was established when the lock was taken and counters can only fall.
    assign master_v_o = !reset_i && (lock_r ? req_v_i[lock_idx_r] : (|elig));
    assign accept     = master_v_o && master_rdy_i;

    always_comb begin
        req_yumi_o = '0;
        if (accept) begin
            req_yumi_o[grant] = 1'b1;
        end
    end

    assign master_type_o = req_type_i[grant];
    assign master_addr_o = req_addr_i[grant_int*addr_width_p +: addr_width_p];
    assign master_data_o = req_data_i[grant_int*data_width_p +: data_width_p];
    assign master_mask_o = req_mask_i[grant_int*mask_width_lp +: mask_width_lp];
    assign master_opq_o  = {grant, req_opq_i[grant_int*opq_width_lp +: opq_width_lp]};

    // ---------------------------------------------------------------------
    // Response routing
    // ---------------------------------------------------------------------
    logic [id_width_lp-1:0] ret_idx;
    logic                   ret_ok;

    assign ret_idx = master_ret_opq_i[load_id_width_p-1 -: id_width_lp];
    assign ret_ok  = int'(ret_idx) < num_req_p;

    always_comb begin
        resp_v_o = '0;
        if (!reset_i && master_ret_v_i && ret_ok) begin
            resp_v_o[ret_idx] = 1'b1;
        end
    end

    assign resp_data_o = master_ret_data_i;
    assign resp_opq_o  = master_ret_opq_i[opq_width_lp-1:0];

    // ---------------------------------------------------------------------
    // Next-state: pointer, lock, counters, error
    // ---------------------------------------------------------------------
    always_comb begin
        ptr_n      = ptr_r;
        lock_n     = lock_r;
        lock_idx_n = lock_idx_r;
        err_n      = err_r;

        if (accept) begin
            ptr_n  = (grant_int == num_req_p - 1) ? '0 : grant + 1'b1;
            lock_n = 1'b0;
        end else if (lock_r && !req_v_i[lock_idx_r]) begin
            // Locked requester withdrew its request: protocol violation.
            err_n  = 1'b1;
            lock_n = 1'b0;
        end else if (master_v_o && !master_rdy_i) begin
            lock_n     = 1'b1;
            lock_idx_n = grant;
        end

        if (master_ret_v_i && !ret_ok) begin
            err_n = 1'b1;
        end

        for (int i = 0; i < num_req_p; i++) begin
            logic inc;
            logic dec;
            inc      = accept && !req_type_i[grant] && (grant == id_width_lp'(i));
            dec      = master_ret_v_i && ret_ok && (ret_idx == id_width_lp'(i));
            cnt_n[i] = cnt_r[i];
            // A return with nothing outstanding is an error even when a new
            // load is accepted in the same cycle.
            if (dec && (cnt_r[i] == '0)) begin
                err_n = 1'b1;
            end
            if (inc && !dec) begin
                cnt_n[i] = cnt_r[i] + 1'b1;
            end else if (dec && !inc && (cnt_r[i] != '0)) begin
                cnt_n[i] = cnt_r[i] - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            ptr_r      <= '0;
            lock_r     <= 1'b0;
            lock_idx_r <= '0;
            err_r      <= 1'b0;
            for (int i = 0; i < num_req_p; i++) begin
                cnt_r[i] <= '0;
            end
        end else begin
            ptr_r      <= ptr_n;
            lock_r     <= lock_n;
            lock_idx_r <= lock_idx_n;
            err_r      <= err_n;
            for (int i = 0; i < num_req_p; i++) begin
                cnt_r[i] <= cnt_n[i];
            end
        end
    end

    // ---------------------------------------------------------------------
    // Status
    // ---------------------------------------------------------------------
    always_comb begin
        idle_o = !lock_r;
        for (int i = 0; i < num_req_p; i++) begin
            if (cnt_r[i] != '0) begin
                idle_o = 1'b0;
            end
        end
    end

    assign err_o = err_r;

endmodule

// File: tb/tb_brg_xcel_master_arbiter.sv
// -----------------------------------------------------------------------------
// Directed bench for brg_xcel_master_arbiter (default parameters: 2 requesters,
// 32-bit data/addr, 11-bit load_id, 16 outstanding loads per requester).
// Inputs change on the falling edge; outputs are sampled 1 ns later.
// -----------------------------------------------------------------------------
module tb_brg_xcel_master_arbiter;

    localparam int n_lp   = 2;
    localparam int dw_lp  = 32;
    localparam int aw_lp  = 32;
    localparam int lw_lp  = 11;
    localparam int ow_lp  = 10;
    localparam int mw_lp  = 4;

    // -------------------------------------------------------------- clock/reset
    logic clk = 1'b0;
    logic reset_i;
    always #5 clk = ~clk;

    logic [n_lp-1:0]       req_v, req_type, req_yumi;
    logic [n_lp*aw_lp-1:0] req_addr;
    logic [n_lp*dw_lp-1:0] req_data;
    logic [n_lp*mw_lp-1:0] req_mask;
    logic [n_lp*ow_lp-1:0] req_opq;
    logic                  master_v, master_type, master_rdy;
    logic [aw_lp-1:0]      master_addr;
    logic [dw_lp-1:0]      master_data;
    logic [mw_lp-1:0]      master_mask;
    logic [lw_lp-1:0]      master_opq;
    logic                  ret_v;
    logic [dw_lp-1:0]      ret_data;
    logic [lw_lp-1:0]      ret_opq;
    logic [n_lp-1:0]       resp_v;
    logic [dw_lp-1:0]      resp_data;
    logic [ow_lp-1:0]      resp_opq;
    logic                  idle, err;

    brg_xcel_master_arbiter dut (
        .clk_i             (clk),
        .reset_i           (reset_i),
        .req_v_i           (req_v),
        .req_type_i        (req_type),
        .req_addr_i        (req_addr),
        .req_data_i        (req_data),
        .req_mask_i        (req_mask),
        .req_opq_i         (req_opq),
        .req_yumi_o        (req_yumi),
        .master_v_o        (master_v),
        .master_type_o     (master_type),
        .master_addr_o     (master_addr),
        .master_data_o     (master_data),
        .master_mask_o     (master_mask),
        .master_opq_o      (master_opq),
        .master_rdy_i      (master_rdy),
        .master_ret_v_i    (ret_v),
        .master_ret_data_i (ret_data),
        .master_ret_opq_i  (ret_opq),
        .resp_v_o          (resp_v),
        .resp_data_o       (resp_data),
        .resp_opq_o        (resp_opq),
        .idle_o            (idle),
        .err_o             (err)
    );

    // -------------------------------------------------------------- scoreboard
    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // -------------------------------------------------------------- drivers
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_req(input int idx, input logic v, input logic t,
                           input logic [31:0] addr, input logic [9:0] opq);
        req_v[idx]                  = v;
        req_type[idx]               = t;
        req_addr[idx*aw_lp +: aw_lp] = addr;
        req_data[idx*dw_lp +: dw_lp] = addr ^ 32'hA5A5_0000;
        req_mask[idx*mw_lp +: mw_lp] = 4'hF;
        req_opq[idx*ow_lp +: ow_lp]  = opq;
    endtask

    // One-cycle return on the response port, then idle it again.
    task automatic do_ret(input logic [10:0] id);
        ret_v    = 1'b1;
        ret_opq  = id;
        ret_data = 32'hD00D_0000 | 32'(id);
        tick();
        ret_v    = 1'b0;
    endtask

    int acc;

    initial begin
        reset_i    = 1'b1;
        req_v      = '0;
        req_type   = '0;
        req_addr   = '0;
        req_data   = '0;
        req_mask   = '0;
        req_opq    = '0;
        master_rdy = 1'b0;
        ret_v      = 1'b0;
        ret_data   = '0;
        ret_opq    = '0;
        tick();
        #1;
        check("reset_idle",     32'(idle),     32'd1);
        check("reset_master_v", 32'(master_v), 32'd0);
        check("reset_err",      32'(err),      32'd0);
        reset_i = 1'b0;
        tick();

        // ---------------- round-robin between two continuous loaders
        set_req(0, 1'b1, 1'b0, 32'h1000, 10'd2);
        set_req(1, 1'b1, 1'b0, 32'h2000, 10'd5);
        master_rdy = 1'b1;
        exp_q.push_back(32'h1); exp_q.push_back(32'h2);
        exp_q.push_back(32'h1); exp_q.push_back(32'h2);
        for (int k = 0; k < 4; k++) begin
            #1;
            check("rr_yumi", 32'(req_yumi), exp_q.pop_front());
            if (k == 1) check("rr_opq_req1", 32'(master_opq), 32'h405);
            if (k == 0) check("rr_addr_req0", master_addr, 32'h1000);
            tick();
        end
        req_v = '0;
        #1;
        check("rr_not_idle", 32'(idle), 32'd0);
        do_ret(11'h000); do_ret(11'h000);
        ret_v = 1'b1; ret_opq = 11'h405; #1;
        check("ret_resp_v1",  32'(resp_v),   32'h2);
        check("ret_resp_opq", 32'(resp_opq), 32'd5);
        tick(); ret_v = 1'b0;
        do_ret(11'h405);
        #1;
        check("rr_drained_idle", 32'(idle), 32'd1);

        // ---------------- grant lock while endpoint stalls
        master_rdy = 1'b0;
        set_req(1, 1'b1, 1'b0, 32'h2000, 10'd5);
        #1;
        check("lock_v",    32'(master_v), 32'd1);
        check("lock_addr", master_addr,   32'h2000);
        tick();
        set_req(0, 1'b1, 1'b0, 32'h1000, 10'd2);
        for (int k = 0; k < 2; k++) begin
            #1;
            check("lock_hold_addr", master_addr,     32'h2000);
            check("lock_hold_yumi", 32'(req_yumi),   32'h0);
            tick();
        end
        master_rdy = 1'b1;
        #1;
        check("lock_release_yumi", 32'(req_yumi), 32'h2);
        tick();
        req_v[1] = 1'b0;
        #1;
        check("after_lock_yumi0", 32'(req_yumi), 32'h1);
        tick();
        req_v = '0;
        do_ret(11'h000); do_ret(11'h405);
        #1;
        check("lock_drained_idle", 32'(idle), 32'd1);

        // ---------------- outstanding limit on requester 0
        set_req(0, 1'b1, 1'b0, 32'h1000, 10'd3);
        acc = 0;
        for (int k = 0; k < 16; k++) begin
            #1;
            if (req_yumi == 2'b01) acc++;
            tick();
        end
        check("limit_16_accepts", 32'(acc), 32'd16);
        #1;
        check("limit_master_v", 32'(master_v), 32'd0);
        ret_v = 1'b1; ret_opq = 11'h003; #1;
        check("limit_ret_resp_v",   32'(resp_v),   32'h1);
        check("limit_ret_resp_opq", 32'(resp_opq), 32'd3);
        tick(); ret_v = 1'b0;
        #1;
        check("limit_next_yumi", 32'(req_yumi), 32'h1);
        tick();
        req_v = '0;

        // ---------------- simultaneous inc/dec at count 7
        for (int k = 0; k < 9; k++) do_ret(11'h003);
        req_v[0] = 1'b1; ret_v = 1'b1; ret_opq = 11'h003; #1;
        check("incdec_yumi",   32'(req_yumi), 32'h1);
        check("incdec_resp_v", 32'(resp_v),   32'h1);
        tick();
        req_v = '0; ret_v = 1'b0;
        #1;
        check("incdec_not_idle", 32'(idle), 32'd0);
        for (int k = 0; k < 6; k++) do_ret(11'h003);
        #1;
        check("cnt7_after6_not_idle", 32'(idle), 32'd0);
        do_ret(11'h003);
        #1;
        check("cnt7_after7_idle", 32'(idle), 32'd1);
        check("no_err_yet",       32'(err),  32'd0);

        // ---------------- underflow on requester 1
        ret_v = 1'b1; ret_opq = 11'h400; #1;
        check("underflow_resp_v", 32'(resp_v), 32'h2);
        tick(); ret_v = 1'b0;
        #1;
        check("underflow_err", 32'(err), 32'd1);
        tick(); tick(); tick();
        #1;
        check("err_sticky", 32'(err), 32'd1);

        // ---------------- asynchronous reset mid-lock
        set_req(0, 1'b1, 1'b0, 32'h1000, 10'd2);
        set_req(1, 1'b1, 1'b0, 32'h2000, 10'd5);
        master_rdy = 1'b1;
        for (int k = 0; k < 5; k++) tick();
        req_v[0]   = 1'b0;
        master_rdy = 1'b0;
        tick();
        req_v[0] = 1'b1;
        #1;
        check("prereset_locked_addr", master_addr, 32'h2000);
        reset_i = 1'b1; ret_v = 1'b1; ret_opq = 11'h000; master_rdy = 1'b1;
        #1;
        check("rst_master_v", 32'(master_v), 32'd0);
        check("rst_yumi",     32'(req_yumi), 32'h0);
        check("rst_resp_v",   32'(resp_v),   32'h0);
        check("rst_idle",     32'(idle),     32'd1);
        check("rst_err",      32'(err),      32'd0);
        tick();
        reset_i = 1'b0; ret_v = 1'b0;
        #1;
        check("post_rst_yumi", 32'(req_yumi),   32'h1);
        check("post_rst_opq",  32'(master_opq), 32'h002);
        tick();
        req_v = '0;
        do_ret(11'h400);
        #1;
        check("stale_ret_err", 32'(err), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
